wind_input_conditioner: RTL and testbench
=========================================

# wind_input_conditioner

- Front end for the runway landing-lights controller.
- Takes the two raw wind-direction switches (x = left, y = right) from the board and produces clean, glitch-free levels plus a periodic one-cycle `step` enable.
- Its job:
  - two-flop synchronize each switch;
  - debounce each synchronized switch with a per-channel stable-count filter;
  - generate the slow advance tick that the downstream lights FSM uses as its clock enable;
  - flag every accepted input change with a one-cycle `changed` pulse.

## Interface

Parameters:
- DEBOUNCE_CYCLES, default 4: consecutive cycles a synchronized level must differ from the current output before it is accepted; legal range ≥1.
- TICK_DIV, default 8: period of `step` in clk cycles; legal range ≥2.

Ports:
- clk, input, 1: single system clock; all flops on its rising edge.
- reset, input, 1: asynchronous, active-high; clears every flop immediately, independent of clk.
- x, input, 1: raw left-wind switch; asynchronous to clk and may bounce.
- y, input, 1: raw right-wind switch; asynchronous to clk and may bounce.
- x_out, output, 1: debounced x.
- y_out, output, 1: debounced y.
- step, output, 1: one-cycle pulse every TICK_DIV cycles.
- changed, output, 1: one-cycle pulse in the first cycle x_out and/or y_out shows a new value.

## Operation

- Synchronizer: two flops per channel (x→xs1→xs; y→ys1→ys). No logic is allowed between the two stages.
- Debounce (x channel; y is identical and independent):
  - Counter cnt_x, width clog2(DEBOUNCE_CYCLES)+1.
  - If xs == x_out: cnt_x ← 0.
  - If xs != x_out and cnt_x == DEBOUNCE_CYCLES−1: x_out ← xs and cnt_x ← 0.
  - Otherwise: cnt_x ← cnt_x+1.
  - A bounce that returns xs to x_out before acceptance clears the counter, so the count restarts from 0.
- Change flag: `changed` is registered. It is 1 in the cycle following any edge at which x_out or y_out was updated, i.e. aligned with the new output value.
  - Simultaneous updates of both channels give one single-cycle pulse.
- Tick generator:
  - Free-running counter tcnt, 0..TICK_DIV−1, wrapping to 0.
  - `step` is registered: step ← (tcnt == TICK_DIV−2), so step is high exactly while tcnt == TICK_DIV−1.
  - tcnt is not affected by input activity or debounce.
- x=1 and y=1 together is passed through unmodified; the downstream FSM owns that case.
- No other state: no FSM beyond the counters above.

## Timing

- Reset values: xs1, xs, ys1, ys, x_out, y_out, changed, step all 0; cnt_x, cnt_y, tcnt all 0.
- Reset asserted mid-operation: every output drops to 0 asynchronously. Partially accumulated debounce counts are discarded.
- Reset release: the first rising edge after deassertion is edge 1. step first rises after edge TICK_DIV−1 and is high during cycle TICK_DIV; period TICK_DIV thereafter.
- Input latency: a new stable x level first sampled at edge 0 appears on x_out after edge DEBOUNCE_CYCLES+1, i.e. DEBOUNCE_CYCLES+2 edges total (6 with defaults). `changed` is high in that same cycle only.
- Minimum accepted pulse: a level held for fewer than DEBOUNCE_CYCLES synchronized cycles produces no output change and no `changed`.
- step and changed can be high in the same cycle. Neither masks the other.
- Width rule: counters compare with ==, never ≥. The counter width must hold DEBOUNCE_CYCLES−1 and TICK_DIV−1 without overflow.

## Test plan

- Reset behaviour: assert reset asynchronously mid-cycle with x=y=1 held and outputs already 1 → x_out, y_out, step and changed go 0 before the next edge. After release, the first step is high in cycle 8 (defaults).
- Clean change: x 0→1 held (defaults) → x_out=1 and changed=1 exactly 6 edges after the first sampling edge. changed=0 on the next cycle. y_out stays 0.
- Bounce rejection: x high for 3 cycles, low 1, high 3, then low → x_out never rises and changed never pulses. Then x held high for 4+ cycles → accepted at latency 6.
- Simultaneous channels: x and y both 0→1 on the same edge → x_out and y_out rise on the same cycle, with a single one-cycle changed pulse. Then x=y=1 is held stably.
- Tick cadence: run 40 cycles with TICK_DIV=8 and random switch activity → step high at cycles 8, 16, 24, 32, 40 only, each exactly one cycle. Repeat with TICK_DIV=2 → step high on alternate cycles.
- Parameter corner: DEBOUNCE_CYCLES=1 → a change is accepted 3 edges after sampling. Any single-cycle xs glitch is accepted, since a filter length of 1 does not reject it.

Source files
------------

// File: rtl/wind_input_conditioner.sv
// Wind-switch front end: two-flop synchronizers, per-channel stable-count debounce,
// a one-cycle change flag and a free-running step tick for the landing-lights FSM.
module wind_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TICK_DIV        = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic x,
    input  logic y,
    output logic x_out,
    output logic y_out,
    output logic step,
    output logic changed
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int TW = $clog2(TICK_DIV);

    localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [TW-1:0] TICK_PRE  = TW'(TICK_DIV - 2);

    logic          xs1, xs, ys1, ys;
    logic [CW-1:0] cnt_x, cnt_y;
    logic [TW-1:0] tcnt;
    logic          acc_x, acc_y;

    // Plain flop pairs, nothing between the stages, so metastability settles in xs1/ys1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            xs1 <= 1'b0;
            xs  <= 1'b0;
            ys1 <= 1'b0;
            ys  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make xs take the old xs1, giving two real stages.
            xs1 <= x;
            xs  <= xs1;
            ys1 <= y;
            ys  <= ys1;
        end
    end

    always_comb begin
        acc_x = (xs != x_out) && (cnt_x == CNT_LAST);
        acc_y = (ys != y_out) && (cnt_y == CNT_LAST);
    end

    // A bounce back to the current output restarts the count from zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_out <= 1'b0;
            cnt_x <= '0;
        end else if (xs == x_out) begin
            cnt_x <= '0;
        end else if (acc_x) begin
            x_out <= xs;
            cnt_x <= '0;
        end else begin
            cnt_x <= cnt_x + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            y_out <= 1'b0;
            cnt_y <= '0;
        end else if (ys == y_out) begin
            cnt_y <= '0;
        end else if (acc_y) begin
            y_out <= ys;
            cnt_y <= '0;
        end else begin
            cnt_y <= cnt_y + CW'(1);
        end
    end

    // changed lines up with the new output value; both channels together give one pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            changed <= 1'b0;
        end else begin
            changed <= acc_x | acc_y;
        end
    end

    // step is registered off TICK_DIV-2 so it is high exactly while tcnt == TICK_DIV-1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tcnt <= '0;
            step <= 1'b0;
        end else begin
            tcnt <= (tcnt == TICK_LAST) ? '0 : tcnt + TW'(1);
            step <= (tcnt == TICK_PRE);
        end
    end

endmodule

// File: tb/tb_wind_input_conditioner.sv
// Directed bench for wind_input_conditioner: a default instance (4/8) and a
// corner instance (DEBOUNCE_CYCLES=1, TICK_DIV=2) share the same stimulus.
module tb_wind_input_conditioner;

    logic clk;
    logic reset;
    logic x, y;
    logic x_out, y_out, step, changed;
    logic x_out2, y_out2, step2, changed2;

    int total = 0;
    int bad   = 0;
    int k     = 0;   // rising edges since the last reset release

    wind_input_conditioner #(.DEBOUNCE_CYCLES(4), .TICK_DIV(8)) dut (
        .clk(clk), .reset(reset), .x(x), .y(y),
        .x_out(x_out), .y_out(y_out), .step(step), .changed(changed)
    );

    wind_input_conditioner #(.DEBOUNCE_CYCLES(1), .TICK_DIV(2)) dut2 (
        .clk(clk), .reset(reset), .x(x), .y(y),
        .x_out(x_out2), .y_out(y_out2), .step(step2), .changed(changed2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic got, input logic exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s edge=%0d got=%0b exp=%0b", tag, k, got, exp);
        end
    endtask

    // Advance one edge and land 1 ns after it, where outputs are sampled and inputs driven.
    task automatic tick();
        @(posedge clk);
        #1;
        k++;
    endtask

    task automatic settle(input logic xv, input logic yv);
        x = xv;
        y = yv;
        repeat (10) tick();
    endtask

    initial begin
        reset = 1'b1;
        x = 1'b0;
        y = 1'b0;

        // Reset state
        #12;
        check("rst_x_out", x_out, 1'b0);
        check("rst_y_out", y_out, 1'b0);
        check("rst_step", step, 1'b0);
        check("rst_changed", changed, 1'b0);
        check("rst_step2", step2, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        k = 0;

        // Tick cadence under random switch activity
        for (int i = 0; i < 40; i++) begin
            tick();
            check("cad_step", step, (k % 8) == 7);
            check("cad_step2", step2, (k % 2) == 1);
            x = 1'($urandom_range(0, 1));
            y = 1'($urandom_range(0, 1));
        end

        // Asynchronous reset mid-cycle with outputs high
        settle(1'b1, 1'b1);
        check("pre_rst_x_out", x_out, 1'b1);
        check("pre_rst_y_out", y_out, 1'b1);
        #3 reset = 1'b1;
        #1;
        check("arst_x_out", x_out, 1'b0);
        check("arst_y_out", y_out, 1'b0);
        check("arst_step", step, 1'b0);
        check("arst_changed", changed, 1'b0);
        check("arst_x_out2", x_out2, 1'b0);
        x = 1'b0;
        y = 1'b0;
        #2 reset = 1'b0;
        k = 0;
        for (int i = 1; i <= 9; i++) begin
            tick();
            check("first_step", step, i == 7);
        end

        // Clean change on x: latency 6 for default, 3 for DEBOUNCE_CYCLES=1
        settle(1'b0, 1'b0);
        x = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            check("clean_x_out", x_out, i >= 6);
            check("clean_changed", changed, i == 6);
            check("clean_y_out", y_out, 1'b0);
            check("clean_x_out2", x_out2, i >= 3);
            check("clean_changed2", changed2, i == 3);
        end

        // Bounce rejection: 3 high, 1 low, 3 high, then low
        settle(1'b0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            x = (i < 3) || (i >= 4 && i < 7);
            tick();
            check("bounce_x_out", x_out, 1'b0);
            check("bounce_changed", changed, 1'b0);
        end
        x = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            check("held_x_out", x_out, i >= 6);
            check("held_changed", changed, i == 6);
        end

        // Simultaneous channels: one pulse, then stable hold
        settle(1'b0, 1'b0);
        x = 1'b1;
        y = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            check("sim_x_out", x_out, i >= 6);
            check("sim_y_out", y_out, i >= 6);
            check("sim_changed", changed, i == 6);
        end

        // Single-cycle glitch: passes with DEBOUNCE_CYCLES=1, rejected by default
        settle(1'b0, 1'b0);
        x = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            x = 1'b0;
            check("glitch_x_out2", x_out2, i == 3);
            check("glitch_changed2", changed2, i == 3 || i == 4);
            check("glitch_x_out", x_out, 1'b0);
            check("glitch_changed", changed, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
